text_banner_overlay: RTL and testbench

Parametrised block-letter text renderer for the VGA path. Given the current `Hcount`/`Vcount`, it outputs a 12-bit colour for a one-line string of up to `N_CHARS` glyphs from a built-in 5x5 font, scaled by a power-of-two cell size. The string is held in a writable character buffer. The block supports off, steady, blink and fade-in display modes, all frame-synchronised. It replaces hand-coded per-screen rectangle decoders such as the game-over screen; its reset contents spell "GAMEOVER".

---
 rtl/text_banner_overlay.sv | 142 ++++++++++++++
 tb/tb_text_banner_overlay.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/text_banner_overlay.sv
// text_banner_overlay: two-stage 5x5 block-letter string renderer with
// off/steady/blink/fade-in modes, frame-synchronised to Hcount=Vcount=0.
module text_banner_overlay #(
    parameter int          N_CHARS          = 8,
    parameter int          CELL_LOG2        = 3,
    parameter int          X0               = 220,
    parameter int          Y0               = 110,
    parameter logic [11:0] FG_RGB           = 12'hFFF,
    parameter logic [11:0] BG_RGB           = 12'h000,
    parameter int          BLINK_FRAMES     = 30,
    parameter int          FADE_STEP_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Hcount,
    input  logic [15:0] Vcount,
    input  logic [1:0]  mode,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [2:0]  wr_char,
    output logic [3:0]  r_red,
    output logic [3:0]  r_green,
    output logic [3:0]  r_blue
);
    typedef enum logic [1:0] {M_OFF, M_STEADY, M_BLINK, M_FADE} mode_t;

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int FW = $clog2(FADE_STEP_FRAMES + 1);
    localparam logic [31:0] X_LO = 32'(X0);
    localparam logic [31:0] X_HI = 32'(X0 + N_CHARS * (8 << CELL_LOG2));
    localparam logic [31:0] Y_LO = 32'(Y0);
    localparam logic [31:0] Y_HI = 32'(Y0 + (5 << CELL_LOG2));
    // "GAMEOVER", slot 0 in the low bits; upper slots blank
    localparam logic [47:0] RESET_TEXT = {24'd0, 3'd7, 3'd4, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

    function automatic logic [4:0] glyph_row(input logic [2:0] code, input logic [2:0] row);
        logic [24:0] g;
        case (code)
            3'd1:    g = {5'h1F, 5'h10, 5'h17, 5'h11, 5'h1F};
            3'd2:    g = {5'h1F, 5'h11, 5'h1F, 5'h11, 5'h11};
            3'd3:    g = {5'h11, 5'h1B, 5'h15, 5'h11, 5'h11};
            3'd4:    g = {5'h1F, 5'h10, 5'h1E, 5'h10, 5'h1F};
            3'd5:    g = {5'h1F, 5'h11, 5'h11, 5'h11, 5'h1F};
            3'd6:    g = {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
            3'd7:    g = {5'h1E, 5'h11, 5'h1E, 5'h12, 5'h11};
            default: g = 25'd0;
        endcase
        return (row < 3'd5) ? 5'(g >> (5'd20 - 5'd5 * 5'(row))) : 5'd0;
    endfunction

    function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [31:0]   x, y, xr, yr;
    logic          fs, entry, bwrap, fwrap, in_d, lit;
    logic [3:0]    slot_d;
    logic [2:0]    col_d, row_d, code_d;
    logic [4:0]    sh;
    logic [11:0]   faded, rgb_d, rgb_q;
    mode_t         mode_q, mode_d, md1_q;
    logic          vis_q, vis_d, vis1_q;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [3:0]    lvl_q, lvl_d, lvl1_q;
    logic [2:0]    buf_q [16];
    logic [2:0]    buf_d [16];
    logic          v1_q, in_q;
    logic [2:0]    col_q, row_q, code_q;

    always_comb begin
        x      = {16'd0, Hcount};
        y      = {16'd0, Vcount};
        in_d   = x >= X_LO && x < X_HI && y >= Y_LO && y < Y_HI;
        xr     = x - X_LO;
        yr     = y - Y_LO;
        slot_d = 4'(xr >> (CELL_LOG2 + 3));
        col_d  = 3'(xr >> CELL_LOG2);
        row_d  = 3'(yr >> CELL_LOG2);
        code_d = buf_q[slot_d];
        fs     = Hcount == 16'd0 && Vcount == 16'd0;
        mode_d = fs ? mode_t'(mode) : mode_q;
        entry  = mode_d != mode_q;
        bwrap  = bcnt_q + BW'(1) == BW'(BLINK_FRAMES);
        fwrap  = fcnt_q + FW'(1) == FW'(FADE_STEP_FRAMES);
        bcnt_d = !(fs && mode_d == M_BLINK) ? bcnt_q : (entry || bwrap) ? '0 : bcnt_q + BW'(1);
        vis_d  = !(fs && mode_d == M_BLINK) ? vis_q : entry ? 1'b1 : bwrap ? ~vis_q : vis_q;
        fcnt_d = !(fs && mode_d == M_FADE) ? fcnt_q : (entry || fwrap) ? '0 : fcnt_q + FW'(1);
        lvl_d  = !(fs && mode_d == M_FADE) ? lvl_q : entry ? 4'd0 :
                 (fwrap && lvl_q != 4'd15) ? lvl_q + 4'd1 : lvl_q;
        buf_d  = buf_q;
        if (wr_en && 32'(wr_addr) < N_CHARS) buf_d[wr_addr] = wr_char;
    end

    always_comb begin
        sh    = glyph_row(code_q, row_q) << col_q;
        lit   = in_q && col_q < 3'd5 && sh[4];
        faded = {min4(FG_RGB[11:8], lvl1_q), min4(FG_RGB[7:4], lvl1_q), min4(FG_RGB[3:0], lvl1_q)};
        rgb_d = (!v1_q || !lit)                ? BG_RGB :
                (md1_q == M_STEADY)            ? FG_RGB :
                (md1_q == M_BLINK && vis1_q)   ? FG_RGB :
                (md1_q == M_FADE)              ? faded  : BG_RGB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_OFF;
            vis_q  <= 1'b1;
            bcnt_q <= '0;
            fcnt_q <= '0;
            lvl_q  <= 4'd0;
            for (int i = 0; i < 16; i++) buf_q[i] <= (i < N_CHARS) ? RESET_TEXT[3*i +: 3] : 3'd0;
            v1_q   <= 1'b0;
            in_q   <= 1'b0;
            col_q  <= 3'd0;
            row_q  <= 3'd0;
            code_q <= 3'd0;
            md1_q  <= M_OFF;
            vis1_q <= 1'b1;
            lvl1_q <= 4'd0;
            rgb_q  <= 12'd0;
        end else begin
            mode_q <= mode_d;
            vis_q  <= vis_d;
            bcnt_q <= bcnt_d;
            fcnt_q <= fcnt_d;
            lvl_q  <= lvl_d;
            buf_q  <= buf_d;
            v1_q   <= 1'b1;
            in_q   <= in_d;
            col_q  <= col_d;
            row_q  <= row_d;
            code_q <= code_d;
            md1_q  <= mode_d;
            vis1_q <= vis_d;
            lvl1_q <= lvl_d;
            rgb_q  <= rgb_d;
        end
    end

    assign {r_red, r_green, r_blue} = rgb_q;
endmodule

// File: tb/tb_text_banner_overlay.sv
// tb_text_banner_overlay: directed vectors with literal expectations plus a
// per-frame behavioural model compared against the outputs every cycle.
module tb_text_banner_overlay;
    logic        clk = 0, rst_n = 0;
    logic [15:0] Hcount = 16'd999, Vcount = 16'd999;
    logic [1:0]  mode = 2'd0;
    logic        wr_en = 0;
    logic [3:0]  wr_addr = 0;
    logic [2:0]  wr_char = 0;
    logic [3:0]  r_red, r_green, r_blue;
    int          checks = 0, failures = 0;

    localparam int BLINK = 2, FADE = 1;

    text_banner_overlay #(.BLINK_FRAMES(BLINK), .FADE_STEP_FRAMES(FADE)) dut (
        .clk(clk), .rst_n(rst_n), .Hcount(Hcount), .Vcount(Vcount), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .r_red(r_red), .r_green(r_green), .r_blue(r_blue));

    always #5 clk = ~clk;

    int font [8][5] = '{'{0, 0, 0, 0, 0}, '{'h1F, 'h10, 'h17, 'h11, 'h1F},
                        '{'h1F, 'h11, 'h1F, 'h11, 'h11}, '{'h11, 'h1B, 'h15, 'h11, 'h11},
                        '{'h1F, 'h10, 'h1E, 'h10, 'h1F}, '{'h1F, 'h11, 'h11, 'h11, 'h1F},
                        '{'h11, 'h11, 'h11, 'h0A, 'h04}, '{'h1E, 'h11, 'h1E, 'h12, 'h11}};
    int go_text [8] = '{1, 2, 3, 4, 5, 6, 4, 7};

    // Model state: active mode and frame starts seen since it was entered
    int          am = 0, fse = 0;
    int          mbuf [8];
    logic [11:0] p1 = 0, exp_q = 0;
    bit          p1v = 0;

    function automatic logic [11:0] model_px(input int x, input int y);
        int xr, yr, slot, col, row, lvl;
        bit lit;
        if (x < 220 || x >= 220 + 8 * 64 || y < 110 || y >= 110 + 40) return 12'h000;
        xr = x - 220; yr = y - 110;
        slot = xr / 64; col = (xr / 8) % 8; row = yr / 8;
        lit = col < 5 && ((font[mbuf[slot]][row] >> (4 - col)) & 1) == 1;
        lvl = (fse / FADE > 15) ? 15 : fse / FADE;
        if (!lit) return 12'h000;
        case (am)
            1: return 12'hFFF;
            2: return ((fse / BLINK) % 2 == 0) ? 12'hFFF : 12'h000;
            3: return {3{4'(lvl)}};
            default: return 12'h000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am = 0; fse = 0; p1v = 0; exp_q = 0; p1 = 0;
            for (int i = 0; i < 8; i++) mbuf[i] = go_text[i];
        end else begin
            if (Hcount == 0 && Vcount == 0) begin
                if (int'(mode) != am) begin am = int'(mode); fse = 0; end
                else fse++;
            end
            exp_q = p1v ? p1 : 12'h000;
            p1 = model_px(int'(Hcount), int'(Vcount));
            p1v = 1;
            if (wr_en && wr_addr < 8) mbuf[wr_addr] = int'(wr_char);
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({r_red, r_green, r_blue} !== exp_q) begin
            failures++;
            $display("FAIL model t=%0t got=%h exp=%h", $time, {r_red, r_green, r_blue}, exp_q);
        end
    end

    task automatic check(input string name, input logic [11:0] exp);
        checks++;
        if ({r_red, r_green, r_blue} !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, {r_red, r_green, r_blue}, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic we = 0,
                       input logic [3:0] a = 0, input logic [2:0] c = 0);
        @(negedge clk);
        Hcount = 16'(x); Vcount = 16'(y);
        wr_en = we; wr_addr = a; wr_char = c;
        @(posedge clk);
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [11:0] exp);
        pix(x, y);
        pix(999, 999);
        #1 check(name, exp);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        mode = m;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset_zero", 12'h000);
        @(negedge clk); #2 rst_n = 1;
        set_mode(2'b01);
        pix(0, 0);
        probe("steady_origin", 220, 110, 12'hFFF);
        probe("g_row1_col1", 228, 118, 12'h000);
        probe("gap_col5", 260, 110, 12'h000);
        probe("left_of_region", 219, 110, 12'h000);
        probe("right_edge", 732, 110, 12'h000);
        probe("a_slot1", 284, 110, 12'hFFF);
        pix(999, 999, 1, 4'd0, 3'd0);
        probe("write_blank", 220, 110, 12'h000);
        pix(999, 999, 1, 4'd9, 3'd5);
        probe("write_oob_ignored", 284, 110, 12'hFFF);
        pix(220, 110, 1, 4'd0, 3'd1);
        pix(999, 999);
        #1 check("same_cycle_old", 12'h000);
        probe("after_write", 220, 110, 12'hFFF);
        set_mode(2'b10);
        for (int f = 0; f < 5; f++) begin
            pix(0, 0);
            probe($sformatf("blink_f%0d", f), 220, 110, (f < 2 || f == 4) ? 12'hFFF : 12'h000);
        end
        set_mode(2'b11);
        for (int k = 0; k < 17; k++) begin
            pix(0, 0);
            probe($sformatf("fade_k%0d", k), 220, 110, {3{4'((k > 15) ? 15 : k)}});
        end
        set_mode(2'b01);
        pix(0, 0);
        probe("steady_again", 220, 110, 12'hFFF);
        pix(100, 110);
        set_mode(2'b00);
        probe("midframe_hold", 220, 110, 12'hFFF);
        pix(0, 0);
        probe("off_next_frame", 220, 110, 12'h000);
        pix(999, 999, 1, 4'd0, 3'd0);
        set_mode(2'b11);
        for (int f = 0; f < 8; f++) pix(0, 0);
        probe("fade_level7", 284, 110, 12'h777);
        @(negedge clk); #2 rst_n = 0;
        #1 check("reset_mid_fade", 12'h000);
        @(negedge clk); #2 rst_n = 1;
        pix(0, 0);
        probe("fade_level0_restored", 220, 110, 12'h000);
        pix(0, 0);
        probe("fade_level1_gameover", 220, 110, 12'h111);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
